// File: rtl/fpg8_pkg.sv
// Shared types and constants for the program loader slice.
package fpg8_pkg;

  localparam int RAM_DEPTH = 4096;
  localparam int WORD_W    = 16;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_WRITE,
    ST_SUM_HI,
    ST_SUM_LO,
    ST_DONE,
    ST_ERROR
  } loader_state_t;

  // States in which the loader consumes a byte from the stream.
  function automatic logic is_rx_state(input loader_state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
           (s == ST_DATA_LO) || (s == ST_SUM_HI) || (s == ST_SUM_LO);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and RAM write port of the program loader.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 12
) ();
  import fpg8_pkg::*;

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  ram_w_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [WORD_W-1:0]     ram_w_data;

  // Loader side: consumes bytes, drives the RAM write port.
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, ram_w_en, ram_addr, ram_w_data
  );

  // Environment side: byte source and RAM.
  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, ram_w_en, ram_addr, ram_w_data
  );

endinterface

// File: rtl/program_loader.sv
// Framed serial program loader: LEN(2) + N words (big-endian) + SUM(2).
// Writes words to RAM from BASE_ADDR and holds the CPU until the sum checks.
module program_loader
  import fpg8_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  program_loader_if.master      bus,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [12:0]           words_loaded
);

  // Largest legal word count is a full RAM image.
  localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  loader_state_t         state_reg, state_next;
  logic [15:0]           len_reg, len_next;
  logic [7:0]            hi_reg, hi_next;
  logic [DATA_WIDTH-1:0] acc_reg, acc_next;
  logic [12:0]           words_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic                  xfer;
  logic [16:0]           len_rx;
  logic [12:0]           words_inc;

  assign xfer      = bus.byte_valid & bus.byte_ready;
  assign len_rx    = {1'b0, hi_reg, bus.byte_data};
  assign words_inc = words_loaded + 13'd1;

  // Next-state and datapath updates; one byte per transfer, one word per WRITE.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    hi_next    = hi_reg;
    acc_next   = acc_reg;
    words_next = words_loaded;
    addr_next  = bus.ram_addr;
    wdata_next = bus.ram_w_data;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_next = ST_LEN_HI;
          words_next = '0;
          acc_next   = '0;
          addr_next  = BASE;
        end
      end
      ST_LEN_HI: begin
        if (xfer) begin
          hi_next    = bus.byte_data;
          state_next = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (xfer) begin
          len_next = len_rx[15:0];
          // Zero-length or larger-than-RAM images are rejected up front.
          if (len_rx != 17'd0 && len_rx <= MAX_LEN) state_next = ST_DATA_HI;
          else                                      state_next = ST_ERROR;
        end
      end
      ST_DATA_HI: begin
        if (xfer) begin
          hi_next    = bus.byte_data;
          state_next = ST_DATA_LO;
        end
      end
      ST_DATA_LO: begin
        if (xfer) begin
          wdata_next = {hi_reg, bus.byte_data};
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        words_next = words_inc;
        addr_next  = bus.ram_addr + 1'b1;
        acc_next   = acc_reg + bus.ram_w_data;
        state_next = ({3'b000, words_inc} == len_reg) ? ST_SUM_HI : ST_DATA_HI;
      end
      ST_SUM_HI: begin
        if (xfer) begin
          hi_next    = bus.byte_data;
          state_next = ST_SUM_LO;
        end
      end
      ST_SUM_LO: begin
        if (xfer) state_next = ({hi_reg, bus.byte_data} == acc_reg) ? ST_DONE : ST_ERROR;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      len_reg        <= '0;
      hi_reg         <= '0;
      acc_reg        <= '0;
      words_loaded   <= '0;
      bus.ram_addr   <= BASE;
      bus.ram_w_data <= '0;
      bus.ram_w_en   <= 1'b0;
      bus.byte_ready <= 1'b0;
      cpu_hold       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      hi_reg         <= hi_next;
      acc_reg        <= acc_next;
      words_loaded   <= words_next;
      bus.ram_addr   <= addr_next;
      bus.ram_w_data <= wdata_next;
      bus.ram_w_en   <= (state_next == ST_WRITE);
      bus.byte_ready <= is_rx_state(state_next);
      // ERROR keeps the CPU held so a corrupt image never runs.
      cpu_hold       <= !((state_next == ST_IDLE) || (state_next == ST_DONE));
      busy           <= !((state_next == ST_IDLE) || (state_next == ST_DONE) ||
                          (state_next == ST_ERROR));
      done           <= (state_next == ST_DONE);
      error          <= (state_next == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: two instances (base 0 and base 4094).
module tb_program_loader;
  import fpg8_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_drv;
  logic       valid_drv;
  logic [7:0] data_drv;
  int         sel;

  logic        start0, start1;
  logic        cpu_hold0, busy0, done0, error0;
  logic        cpu_hold1, busy1, done1, error1;
  logic [12:0] wl0, wl1;

  program_loader_if #(.ADDR_WIDTH(12)) if0 ();
  program_loader_if #(.ADDR_WIDTH(12)) if1 ();

  assign start0         = start_drv && (sel == 0);
  assign start1         = start_drv && (sel == 1);
  assign if0.byte_valid = valid_drv && (sel == 0);
  assign if1.byte_valid = valid_drv && (sel == 1);
  assign if0.byte_data  = data_drv;
  assign if1.byte_data  = data_drv;

  program_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .bus(if0),
    .cpu_hold(cpu_hold0), .busy(busy0), .done(done0), .error(error0),
    .words_loaded(wl0)
  );

  program_loader #(.ADDR_WIDTH(12), .DATA_WIDTH(16), .BASE_ADDR(4094)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .bus(if1),
    .cpu_hold(cpu_hold1), .busy(busy1), .done(done1), .error(error1),
    .words_loaded(wl1)
  );

  // Views of the selected instance
  logic        rdy, hold, bsy, dn, er;
  logic [12:0] wl;
  assign rdy  = (sel == 1) ? if1.byte_ready : if0.byte_ready;
  assign hold = (sel == 1) ? cpu_hold1 : cpu_hold0;
  assign bsy  = (sel == 1) ? busy1 : busy0;
  assign dn   = (sel == 1) ? done1 : done0;
  assign er   = (sel == 1) ? error1 : error0;
  assign wl   = (sel == 1) ? wl1 : wl0;

  // RAM models and write monitor
  logic [15:0] mem0 [RAM_DEPTH];
  logic [15:0] mem1 [RAM_DEPTH];
  int          wcnt0 = 0;
  int          wcnt1 = 0;
  int          viol  = 0;
  logic [11:0] last_addr1 = '0;

  always @(negedge clk) begin
    if (if0.ram_w_en) begin
      mem0[if0.ram_addr] = if0.ram_w_data;
      wcnt0++;
    end
    if (if1.ram_w_en) begin
      mem1[if1.ram_addr] = if1.ram_w_data;
      last_addr1 = if1.ram_addr;
      wcnt1++;
    end
    if ((if0.ram_w_en && if0.byte_ready) || (if1.ram_w_en && if1.byte_ready)) viol++;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    valid_drv = 1'b0;
    repeat (gap) @(negedge clk);
    valid_drv = 1'b1;
    data_drv  = b;
    t = 0;
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) check("byte_ready_timeout", 32'(rdy), 32'd1);
    @(negedge clk);
    valid_drv = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] q[$], input int maxgap);
    foreach (q[i]) send_byte(q[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  // Start pulse, optionally with a byte offered in the same IDLE cycle.
  task automatic pulse_start(input logic with_valid);
    start_drv = 1'b1;
    valid_drv = with_valid;
    data_drv  = 8'hFF;
    @(negedge clk);
    start_drv = 1'b0;
    valid_drv = 1'b0;
    check("start_ready", 32'(rdy), 32'd1);
    check("start_hold", 32'(hold), 32'd1);
    check("start_busy", 32'(bsy), 32'd1);
    check("start_words", 32'(wl), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic exp_done, input logic exp_err,
                              input logic exp_hold, input int exp_wl);
    $display("load %s: done=%0b error=%0b hold=%0b words=%0d", tag, dn, er, hold, wl);
    check({tag, "_done"}, 32'(dn), 32'(exp_done));
    check({tag, "_error"}, 32'(er), 32'(exp_err));
    check({tag, "_hold"}, 32'(hold), 32'(exp_hold));
    check({tag, "_busy"}, 32'(bsy), 32'd0);
    check({tag, "_ready"}, 32'(rdy), 32'd0);
    check({tag, "_words"}, 32'(wl), 32'(exp_wl));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(if0.byte_ready), 32'd0);
    check({tag, "_wen"}, 32'(if0.ram_w_en), 32'd0);
    check({tag, "_addr"}, 32'(if0.ram_addr), 32'd0);
    check({tag, "_wdata"}, 32'(if0.ram_w_data), 32'd0);
    check({tag, "_hold"}, 32'(cpu_hold0), 32'd0);
    check({tag, "_busy"}, 32'(busy0), 32'd0);
    check({tag, "_done"}, 32'(done0), 32'd0);
    check({tag, "_error"}, 32'(error0), 32'd0);
    check({tag, "_words"}, 32'(wl0), 32'd0);
    check({tag, "_addr1"}, 32'(if1.ram_addr), 32'd4094);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fr[$];
    logic [15:0] sum;
    int          w_before;

    reset = 1'b1; start_drv = 1'b0; valid_drv = 1'b0; data_drv = 8'h00; sel = 0;
    foreach (mem0[i]) begin mem0[i] = 16'h0000; mem1[i] = 16'h0000; end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset_values("reset");

    // Nominal, with a byte offered alongside start (must be ignored)
    w_before = wcnt0;
    pulse_start(1'b1);
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
    send_frame(fr, 0);
    check_result("nominal", 1'b1, 1'b0, 1'b0, 2);
    check("nominal_mem0", 32'(mem0[0]), 32'h1234);
    check("nominal_mem1", 32'(mem0[1]), 32'hABCD);
    check("nominal_wcnt", 32'(wcnt0 - w_before), 32'd2);
    check("nominal_addr", 32'(if0.ram_addr), 32'd2);

    // Bad checksum: words still land in RAM, CPU stays held
    mem0[0] = 16'h0000; mem0[1] = 16'h0000;
    pulse_start(1'b0);
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02};
    send_frame(fr, 0);
    check_result("badsum", 1'b0, 1'b1, 1'b1, 2);
    check("badsum_mem0", 32'(mem0[0]), 32'h1234);
    check("badsum_mem1", 32'(mem0[1]), 32'hABCD);

    // Bad lengths: zero and 4097
    w_before = wcnt0;
    pulse_start(1'b0);
    fr = '{8'h00, 8'h00};
    send_frame(fr, 0);
    check_result("len0", 1'b0, 1'b1, 1'b1, 0);
    pulse_start(1'b0);
    fr = '{8'h10, 8'h01};
    send_frame(fr, 0);
    check_result("len4097", 1'b0, 1'b1, 1'b1, 0);
    check("badlen_wcnt", 32'(wcnt0 - w_before), 32'd0);

    // Backpressure: random gaps, identical result
    mem0[0] = 16'h0000; mem0[1] = 16'h0000;
    pulse_start(1'b0);
    fr = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01};
    send_frame(fr, 5);
    check_result("backpressure", 1'b1, 1'b0, 1'b0, 2);
    check("bp_mem0", 32'(mem0[0]), 32'h1234);
    check("bp_mem1", 32'(mem0[1]), 32'hABCD);

    // Address wrap on the base-4094 instance
    sel = 1;
    pulse_start(1'b0);
    fr = '{8'h00, 8'h03, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h03, 8'h00, 8'h06};
    send_frame(fr, 0);
    check_result("wrap", 1'b1, 1'b0, 1'b0, 3);
    check("wrap_mem4094", 32'(mem1[4094]), 32'h0001);
    check("wrap_mem4095", 32'(mem1[4095]), 32'h0002);
    check("wrap_mem0", 32'(mem1[0]), 32'h0003);
    check("wrap_last_addr", 32'(last_addr1), 32'd0);
    check("wrap_addr_after", 32'(if1.ram_addr), 32'd1);
    check("wrap_wcnt", 32'(wcnt1), 32'd3);
    sel = 0;

    // Reset after 5 words of a 10-word load, then a fresh good load
    pulse_start(1'b0);
    fr = '{8'h00, 8'h0A};
    for (int i = 0; i < 5; i++) begin fr.push_back(8'h00); fr.push_back(8'(i + 1)); end
    send_frame(fr, 0);
    @(negedge clk);
    check("midload_words", 32'(wl0), 32'd5);
    check("midload_hold", 32'(cpu_hold0), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_values("midreset");
    check("midreset_mem4", 32'(mem0[4]), 32'h0005);
    pulse_start(1'b0);
    fr = '{8'h00, 8'h01, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
    send_frame(fr, 0);
    check_result("after_reset", 1'b1, 1'b0, 1'b0, 1);
    check("after_reset_mem0", 32'(mem0[0]), 32'h5A5A);

    // Full 4096-word image: word i holds i
    w_before = wcnt0;
    pulse_start(1'b0);
    fr = '{8'h10, 8'h00};
    sum = 16'h0000;
    for (int i = 0; i < RAM_DEPTH; i++) begin
      fr.push_back(8'(i >> 8));
      fr.push_back(8'(i));
      sum = sum + 16'(i);
    end
    fr.push_back(sum[15:8]);
    fr.push_back(sum[7:0]);
    send_frame(fr, 0);
    check_result("full", 1'b1, 1'b0, 1'b0, 4096);
    check("full_sum_const", 32'(sum), 32'hF800);
    check("full_mem0", 32'(mem0[0]), 32'h0000);
    check("full_mem2049", 32'(mem0[2049]), 32'd2049);
    check("full_mem4095", 32'(mem0[4095]), 32'd4095);
    check("full_wcnt", 32'(wcnt0 - w_before), 32'd4096);
    check("full_addr_wrap", 32'(if0.ram_addr), 32'd0);

    check("wen_vs_ready", 32'(viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Serial program loader that fills the 4096 x 16 main RAM from a byte stream and holds the CPU while it writes; it is the writing end of the RAM port that the CPU's MAR/MDR path reads. It accepts a framed image (16-bit word count, big-endian data words, 16-bit checksum), writes each word to consecutive RAM addresses starting at `BASE_ADDR`, and releases the CPU only after the checksum matches. It sits at top level between a UART/byte source and the RAM write port, muxed with the MAR/MDR path while `cpu_hold` is high.

## Interface
- `ADDR_WIDTH`, 12, RAM address width (depth 2^ADDR_WIDTH).
- `DATA_WIDTH`, 16, RAM word width; fixed at 16 (two bytes per word).
- `BASE_ADDR`, 0, first RAM address written.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; arms a load from IDLE, DONE or ERROR.
- `byte_valid`  in  1  source has a byte on `byte_data`.
- `byte_data`  in  8  stream byte.
- `byte_ready`  out  1  loader accepts the byte this cycle; transfer = valid & ready.
- `ram_w_en`  out  1  RAM write strobe, one cycle per word.
- `ram_addr`  out  ADDR_WIDTH  RAM write address.
- `ram_w_data`  out  16  RAM write data.
- `cpu_hold`  out  1  holds CPU in reset and gives the RAM port to the loader.
- `busy`  out  1  load in progress.
- `done`  out  1  last load completed with a good checksum.
- `error`  out  1  last load aborted (bad length or checksum).
- `words_loaded`  out  13  count of words written in the current or last load.

## Operation
- Frame: LEN_HI, LEN_LO, then N x (DATA_HI, DATA_LO), then SUM_HI, SUM_LO. N = {LEN_HI, LEN_LO}.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, SUM_HI, SUM_LO, DONE, ERROR.
- IDLE/DONE/ERROR --start--> LEN_HI. Entering LEN_HI clears `words_loaded`, the checksum accumulator, `done` and `error`, and sets `ram_addr` = BASE_ADDR. `start` in any other state is ignored.
- LEN_LO -> DATA_HI if 1 <= N <= 2^ADDR_WIDTH; otherwise -> ERROR (N = 0 or N > 4096 aborts).
- DATA_HI latches the high byte. DATA_LO latches the low byte -> WRITE.
- WRITE: `ram_w_en` = 1 for one cycle. Then `words_loaded` += 1, `ram_addr` += 1 (wraps mod 2^ADDR_WIDTH), and the accumulator += word (16-bit, carry dropped). Next state is SUM_HI if `words_loaded` reaches N, otherwise DATA_HI.
- SUM_LO: the received sum equal to the accumulator -> DONE, otherwise -> ERROR.
- `byte_ready` = 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, SUM_HI and SUM_LO. A state advances only on a transfer; with `byte_valid` low the FSM waits indefinitely.
- `cpu_hold` = 1 from the LEN_HI entry until DONE. It stays 1 in ERROR, so the CPU never runs a corrupt image. It is 0 in IDLE and DONE.
- `busy` = 1 in every state except IDLE, DONE and ERROR.
- Words already written before an ERROR remain in RAM. There is no rollback.

## Timing
- Reset values: state IDLE; `byte_ready` 0, `ram_w_en` 0, `ram_addr` BASE_ADDR, `ram_w_data` 0, `cpu_hold` 0, `busy` 0, `done` 0, `error` 0, `words_loaded` 0.
- All outputs are registered.
- `start` seen at edge k: LEN_HI is entered and `cpu_hold` = 1 after edge k; `byte_ready` = 1 from cycle k+1.
- Each word takes at least 3 cycles (DATA_HI, DATA_LO, WRITE). `ram_w_en`, `ram_addr` and `ram_w_data` are stable in the same cycle; the RAM captures them on the next edge.
- The DONE/ERROR decision is made on the edge that accepts SUM_LO; `cpu_hold` drops on that same edge when the result is DONE.
- Full-image boundary: N = 4096 with BASE_ADDR = 0 writes addresses 0..4095, and `ram_addr` wraps to 0 after the last write.
- `reset` mid-load returns to IDLE next cycle with all outputs at reset values; a partial RAM image remains.
- `start` and `byte_valid` in the same cycle while in IDLE: the byte is not accepted (`byte_ready` = 0 in IDLE).

## Structure
- Shared package (`fpg8_pkg`): state enum `loader_state_t`, `RAM_DEPTH` = 4096, `WORD_W` = 16.
- Single module with no sub-modules. Mux the RAM port at top level on `cpu_hold` (loader vs MAR/MDR).

## Test plan
- Nominal: start, stream 00 02 12 34 AB CD BE 01 -> writes 0x1234@0 and 0xABCD@1, `done` = 1, `cpu_hold` = 0, `words_loaded` = 2.
- Bad checksum: same frame with sum BE 02 -> `error` = 1, `cpu_hold` stays 1, both RAM words still written.
- Bad length: 00 00 -> ERROR after LEN_LO with no `ram_w_en`. 10 01 (4097) -> ERROR.
- Backpressure: `byte_valid` randomly low for 0-5 cycles -> identical RAM contents and result; `ram_w_en` never high while `byte_ready` is high.
- Wrap: BASE_ADDR = 4094, N = 3 -> writes to 4094, 4095, then 0.
- Reset after 5 words of an N = 10 load -> IDLE next cycle, outputs at reset values; a new start plus a full frame completes with `done` = 1.
